spi_reg_arbiter: RTL and testbench
==================================

# spi_reg_arbiter

Register-bank owner and access arbiter placed behind the SPI slave's register interface. It holds the chip's 8-bit configuration register file and serialises accesses from two requesters:

- the SPI slave, which issues writes via valid/ready and reads via req/valid;
- the core logic, which issues reads and writes via req/gnt.

Arbitration is round-robin, and each access completes as a two-cycle grant/acknowledge transaction.

## Interface
Parameters:
- DEPTH, 16, number of implemented registers, addresses 0..DEPTH-1 (DEPTH ≤ 256).
- IN_WIDTH, 8, register data width.

Ports:
- clk  input  1  internal 250 MHz clock; all logic is on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- spi_iadd  input  8  SPI register address, shared by SPI reads and writes.
- spi_irreg  input  IN_WIDTH  SPI write data.
- spi_irvalid  input  1  SPI write request; held high until spi_irready.
- spi_irready  output  1  one-cycle write acknowledge to the SPI side.
- spi_orreq  input  1  SPI read request; held high until spi_orvalid.
- spi_oreg  output  IN_WIDTH  SPI read data; valid while spi_orvalid is high.
- spi_orvalid  output  1  one-cycle read acknowledge carrying data.
- core_req  input  1  core access request; held high until core_gnt.
- core_we  input  1  core access type: 1 = write, 0 = read.
- core_addr  input  8  core register address.
- core_wdata  input  IN_WIDTH  core write data.
- core_gnt  output  1  one-cycle core acknowledge.
- core_rdata  output  IN_WIDTH  core read data; valid while core_gnt is high on a read.
- addr_err  output  1  one-cycle pulse, coincident with the acknowledge, when the serviced address is ≥ DEPTH.

## Operation
- Register file: DEPTH × IN_WIDTH flops, all reset to 0.
- FSM states:
  - IDLE: wait for a request.
  - ACK: perform the access and drive exactly one acknowledge.
- Transitions:
  - IDLE→ACK when any request is pending.
  - ACK→IDLE unconditionally.
- Request sources, evaluated in IDLE:
  - SPI pending = spi_irvalid | spi_orreq. When both are high, the write is serviced first and the read waits for a later grant.
  - CORE pending = core_req.
- Round-robin:
  - rr_last records the last served source (SPI or CORE) and resets to CORE, so SPI wins the first contention.
  - When both sources are pending, grant the source that is not rr_last.
  - When only one source is pending, grant it. rr_last updates on every grant.
- On the IDLE→ACK edge, latch into internal registers: selected source, operation, address, write data.
- Read data is sampled on the same edge: mem[addr], or 0 if addr ≥ DEPTH. It is loaded into spi_oreg or core_rdata.
- In ACK, only the granted port's acknowledge is high:
  - SPI write: spi_irready = 1; mem[addr] ← latched data on that edge.
  - SPI read: spi_orvalid = 1; spi_oreg holds the data.
  - Core: core_gnt = 1; a write updates mem on that edge, a read presents data on core_rdata.
- Out-of-range address (≥ DEPTH): writes are dropped, reads return 0, and addr_err pulses alongside the acknowledge. The handshake still completes.
- spi_oreg and core_rdata hold their last value outside ACK.

## Timing
- Reset values: spi_irready = 0, spi_orvalid = 0, core_gnt = 0, addr_err = 0, spi_oreg = 0, core_rdata = 0, state = IDLE, rr_last = CORE.
- Latency: a request sampled high in IDLE at edge N gets its acknowledge high in cycle N+1, for exactly one cycle.
- Throughput: at most one access per 2 cycles.
- Requesters drop the request the cycle after the acknowledge. A request still high in IDLE is treated as new: the requester owns that rule, and the arbiter does not filter repeats.
- Write-then-read to the same address: serialised, so the later read returns the new value.
- SPI and core writing the same address back-to-back: the later grant wins.
- Inputs changing during ACK have no effect, because the access uses the latched values.
- rst asserted mid-ACK: the acknowledge drops immediately, the write is not performed, and the FSM returns to IDLE. The pending requester re-requests after reset.

## Test plan
- Reset → all outputs 0. Then an SPI read of addr 3 → spi_orvalid high 1 cycle after the request, spi_oreg = 8'h00.
- SPI write addr 5 data 8'hA5, then SPI read addr 5 → spi_irready pulses once, then spi_orvalid with spi_oreg = 8'hA5.
- spi_irvalid and core_req (write addr 2, 8'h3C) raised in the same cycle after reset → SPI served first (spi_irready), core_gnt 2 cycles later.
- Same contention repeated immediately after a core grant → SPI granted first.
- spi_irvalid and spi_orreq both high (write addr 1, 8'h11, read addr 1) → spi_irready first, then spi_orvalid with spi_oreg = 8'h11.
- Core write to addr DEPTH (16) with data 8'hFF → core_gnt and addr_err pulse together, no register changes. A subsequent core read of addr 16 → core_rdata = 0 with addr_err.
- SPI write addr 7 data 8'h5A with rst pulsed during ACK → no spi_irready after reset, mem[7] = 0. A re-request then completes normally.

Source files
------------

// File: rtl/spi_reg_arbiter.sv
// Configuration register file shared by the SPI slave and the core logic.
// Round-robin arbitration; each access is an IDLE->ACK grant/acknowledge pair.
module spi_reg_arbiter #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          spi_iadd,
  input  logic [IN_WIDTH-1:0] spi_irreg,
  input  logic                spi_irvalid,
  output logic                spi_irready,
  input  logic                spi_orreq,
  output logic [IN_WIDTH-1:0] spi_oreg,
  output logic                spi_orvalid,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [7:0]          core_addr,
  input  logic [IN_WIDTH-1:0] core_wdata,
  output logic                core_gnt,
  output logic [IN_WIDTH-1:0] core_rdata,
  output logic                addr_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  localparam logic SRC_SPI  = 1'b0;
  localparam logic SRC_CORE = 1'b1;

  logic [0:0]          state_q, state_d;
  logic                rr_last_q;
  logic                src_q;
  logic                we_q;
  logic [7:0]          addr_q;
  logic [IN_WIDTH-1:0] wdata_q;
  logic [IN_WIDTH-1:0] spi_oreg_q;
  logic [IN_WIDTH-1:0] core_rdata_q;
  logic [IN_WIDTH-1:0] mem_q [DEPTH];

  logic                spi_pend;
  logic                core_pend;
  logic                grant_spi;
  logic                start;
  logic                sel_src;
  logic                sel_we;
  logic [7:0]          sel_addr;
  logic [IN_WIDTH-1:0] sel_wdata;
  logic                sel_in_range;
  logic [IN_WIDTH-1:0] sel_rdata;
  logic                in_ack;
  logic                addr_in_range_q;

  // Request selection, evaluated only while IDLE.
  always_comb begin
    spi_pend     = spi_irvalid | spi_orreq;
    core_pend    = core_req;
    grant_spi    = spi_pend && (!core_pend || (rr_last_q == SRC_CORE));
    start        = (state_q == ST_IDLE) && (spi_pend || core_pend);
    sel_src      = grant_spi ? SRC_SPI : SRC_CORE;
    // A pending SPI write takes precedence over a pending SPI read.
    sel_we       = grant_spi ? spi_irvalid : core_we;
    sel_addr     = grant_spi ? spi_iadd : core_addr;
    sel_wdata    = grant_spi ? spi_irreg : core_wdata;
    sel_in_range = ({1'b0, sel_addr} < 9'(DEPTH));
    sel_rdata    = '0;
    if (sel_in_range) begin
      sel_rdata = mem_q[sel_addr[AW-1:0]];
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (state_q == ST_IDLE && start) begin
      state_d = ST_ACK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transaction latch: everything the ACK cycle needs is captured at grant time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q    <= SRC_CORE;
      src_q        <= SRC_SPI;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      spi_oreg_q   <= '0;
      core_rdata_q <= '0;
    end else if (start) begin
      rr_last_q <= sel_src;
      src_q     <= sel_src;
      we_q      <= sel_we;
      addr_q    <= sel_addr;
      wdata_q   <= sel_wdata;
      if (!sel_we) begin
        if (sel_src == SRC_SPI) begin
          spi_oreg_q <= sel_rdata;
        end else begin
          core_rdata_q <= sel_rdata;
        end
      end
    end
  end

  assign in_ack          = (state_q == ST_ACK);
  assign addr_in_range_q = ({1'b0, addr_q} < 9'(DEPTH));

  // Writes commit on the edge that closes ACK, so a reset during ACK discards them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (in_ack && we_q && addr_in_range_q) begin
      mem_q[addr_q[AW-1:0]] <= wdata_q;
    end
  end

  assign spi_irready = in_ack && (src_q == SRC_SPI) && we_q;
  assign spi_orvalid = in_ack && (src_q == SRC_SPI) && !we_q;
  assign core_gnt    = in_ack && (src_q == SRC_CORE);
  assign addr_err    = in_ack && !addr_in_range_q;
  assign spi_oreg    = spi_oreg_q;
  assign core_rdata  = core_rdata_q;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Self-checking bench for spi_reg_arbiter: directed scenarios then randomized
// request mixes, checked against a transaction-level model of the register file.
`timescale 1ns/1ps
module tb_spi_reg_arbiter;

  localparam int DEPTH = 16;
  localparam int SPI   = 0;
  localparam int CORE  = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] spi_iadd;
  logic [7:0] spi_irreg;
  logic       spi_irvalid;
  logic       spi_irready;
  logic       spi_orreq;
  logic [7:0] spi_oreg;
  logic       spi_orvalid;
  logic       core_req;
  logic       core_we;
  logic [7:0] core_addr;
  logic [7:0] core_wdata;
  logic       core_gnt;
  logic [7:0] core_rdata;
  logic       addr_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [7:0] mem_m [DEPTH];
  int         rr_last_m;
  logic [7:0] exp_oreg;
  logic [7:0] exp_crdata;

  always #2 clk = ~clk;

  spi_reg_arbiter #(
    .DEPTH    (DEPTH),
    .IN_WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_iadd    (spi_iadd),
    .spi_irreg   (spi_irreg),
    .spi_irvalid (spi_irvalid),
    .spi_irready (spi_irready),
    .spi_orreq   (spi_orreq),
    .spi_oreg    (spi_oreg),
    .spi_orvalid (spi_orvalid),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_rdata  (core_rdata),
    .addr_err    (addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    rr_last_m  = CORE;
    exp_oreg   = 8'h00;
    exp_crdata = 8'h00;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".irready"}, 32'(spi_irready), 0);
    chk({tag, ".orvalid"}, 32'(spi_orvalid), 0);
    chk({tag, ".gnt"},     32'(core_gnt), 0);
    chk({tag, ".err"},     32'(addr_err), 0);
    chk({tag, ".oreg"},    32'(spi_oreg), 32'(exp_oreg));
    chk({tag, ".rdata"},   32'(core_rdata), 32'(exp_crdata));
  endtask

  // Called at a negedge with the DUT idle and at least one request up.
  // Predicts the winner, checks its ACK cycle, retires it, then checks the gap cycle.
  task automatic step_ack(input string tag, input bit scramble);
    bit         sp, cp, we, inr;
    int         src;
    logic [7:0] a, wd, rd;
    sp = spi_irvalid | spi_orreq;
    cp = core_req;
    if (sp && cp) src = (rr_last_m == CORE) ? SPI : CORE;
    else          src = sp ? SPI : CORE;
    if (src == SPI) begin
      we = spi_irvalid; a = spi_iadd; wd = spi_irreg;
    end else begin
      we = core_we; a = core_addr; wd = core_wdata;
    end
    inr = (a < DEPTH);
    rd  = inr ? mem_m[a[3:0]] : 8'h00;
    if (!we) begin
      if (src == SPI) exp_oreg = rd;
      else            exp_crdata = rd;
    end
    @(negedge clk);
    chk({tag, ".irready"}, 32'(spi_irready), 32'(src == SPI && we));
    chk({tag, ".orvalid"}, 32'(spi_orvalid), 32'(src == SPI && !we));
    chk({tag, ".gnt"},     32'(core_gnt), 32'(src == CORE));
    chk({tag, ".err"},     32'(addr_err), 32'(!inr));
    chk({tag, ".oreg"},    32'(spi_oreg), 32'(exp_oreg));
    chk({tag, ".rdata"},   32'(core_rdata), 32'(exp_crdata));
    if (we && inr) mem_m[a[3:0]] = wd;
    rr_last_m = src;
    if (src == SPI) begin
      if (we) spi_irvalid = 1'b0;
      else    spi_orreq = 1'b0;
    end else begin
      core_req = 1'b0;
      // Latched values must shield the access from late input changes.
      if (scramble) begin
        core_addr  = 8'($urandom);
        core_wdata = 8'($urandom);
        core_we    = 1'($urandom);
      end
    end
    @(negedge clk);
    chk_quiet({tag, ".gap"});
  endtask

  task automatic drain(input string tag, input bit scramble);
    int guard = 0;
    while ((spi_irvalid || spi_orreq || core_req) && guard < 8) begin
      step_ack(tag, scramble);
      guard++;
    end
    chk({tag, ".drained"}, 32'(spi_irvalid || spi_orreq || core_req), 0);
  endtask

  initial begin
    rst = 1'b1;
    spi_iadd = '0; spi_irreg = '0; spi_irvalid = 1'b0; spi_orreq = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // SPI read of a fresh register.
    spi_iadd = 8'd3; spi_orreq = 1'b1;
    step_ack("rd3", 1'b0);
    chk("rd3.value", 32'(exp_oreg), 32'h00);

    // Write then read back over SPI.
    spi_iadd = 8'd5; spi_irreg = 8'hA5; spi_irvalid = 1'b1;
    step_ack("wr5", 1'b0);
    spi_orreq = 1'b1;
    step_ack("rd5", 1'b0);
    chk("rd5.value", 32'(spi_oreg), 32'hA5);

    // Reset to restore rr_last = CORE, then SPI/core contention.
    rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset(); @(negedge clk);
    spi_iadd = 8'd9; spi_irreg = 8'h77; spi_irvalid = 1'b1;
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'd2; core_wdata = 8'h3C;
    step_ack("cont1.a", 1'b0);
    chk("cont1.spi_first", 32'(core_req), 1);
    step_ack("cont1.b", 1'b0);

    // Same contention after a core grant: SPI wins again.
    spi_irvalid = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'd2;
    step_ack("cont2.a", 1'b0);
    chk("cont2.spi_first", 32'(spi_irvalid), 0);
    step_ack("cont2.b", 1'b0);
    chk("cont2.rdata", 32'(core_rdata), 32'h3C);

    // SPI write and read together: write first, read sees new data.
    spi_iadd = 8'd1; spi_irreg = 8'h11; spi_irvalid = 1'b1; spi_orreq = 1'b1;
    drain("wrrd1", 1'b0);
    chk("wrrd1.value", 32'(spi_oreg), 32'h11);

    // Out-of-range core write and read.
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'd16; core_wdata = 8'hFF;
    step_ack("oor.wr", 1'b0);
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'd16;
    step_ack("oor.rd", 1'b0);
    chk("oor.rdata", 32'(core_rdata), 32'h00);
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'd0;
    step_ack("oor.mem0", 1'b0);

    // Reset during an SPI write ACK.
    spi_iadd = 8'd7; spi_irreg = 8'h5A; spi_irvalid = 1'b1;
    @(posedge clk); #1;
    chk("rstack.pre", 32'(spi_irready), 1);
    rst = 1'b1; #1;
    chk("rstack.drop", 32'(spi_irready), 0);
    spi_irvalid = 1'b0;
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk_quiet("rstack.after");
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'd7;
    step_ack("rstack.mem7", 1'b0);
    chk("rstack.mem7v", 32'(core_rdata), 32'h00);
    spi_irvalid = 1'b1;
    step_ack("rstack.retry", 1'b0);
    spi_orreq = 1'b1;
    step_ack("rstack.rd", 1'b0);
    chk("rstack.rdv", 32'(spi_oreg), 32'h5A);

    // Randomized request mixes.
    for (int r = 0; r < 80; r++) begin
      int  m;
      m = int'($urandom_range(1, 7));
      spi_iadd   = 8'($urandom_range(0, DEPTH + 3));
      spi_irreg  = 8'($urandom);
      core_addr  = 8'($urandom_range(0, DEPTH + 3));
      core_wdata = 8'($urandom);
      core_we    = 1'($urandom);
      spi_irvalid = m[0];
      spi_orreq   = m[1];
      core_req    = m[2];
      drain("rand", 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
